relogio_ajuste_ctrl: RTL and testbench

- Time-set and sequencing controller for the 24 h hours/minutes/seconds counter.
- Generates the 1 Hz advance strobe for the counter while running.
- Provides a two-button edit mode (mode / increment with auto-repeat) for hours and minutes.
- On leaving edit mode, issues a one-cycle load of the edited time into the counter (seconds cleared by the counter on load).

---
 rtl/relogio_pkg.sv | 40 ++++
 rtl/relogio_ajuste_ctrl_if.sv | 33 +++
 rtl/relogio_btn_repeat.sv | 63 ++++++
 rtl/relogio_ajuste_ctrl.sv | 125 ++++++++++++
 tb/tb_relogio_ajuste_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/relogio_pkg.sv
// ============================================================================
// relogio_pkg : shared types, field limits and helpers for the time-set logic
// Revision    : 1.0
// ============================================================================
`default_nettype none

package relogio_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      SET_H = 2'b01,
      SET_M = 2'b10
   } estado_t;

   localparam int HORAS_MAX = 23;
   localparam int MIN_MAX   = 59;
   localparam int HORAS_W   = 5;
   localparam int MIN_W     = 6;
   localparam int SEG_W     = 6;

   function automatic estado_t prox_estado(input estado_t s);
      case (s)
         RUN:     return SET_H;
         SET_H:   return SET_M;
         default: return RUN;
      endcase
   endfunction

   // Wrap by compare-to-max so out-of-range inputs still return to zero.
   function automatic logic [HORAS_W-1:0] inc_horas(input logic [HORAS_W-1:0] h);
      return (h >= HORAS_W'(HORAS_MAX)) ? '0 : h + 1'b1;
   endfunction

   function automatic logic [MIN_W-1:0] inc_minutos(input logic [MIN_W-1:0] m);
      return (m >= MIN_W'(MIN_MAX)) ? '0 : m + 1'b1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/relogio_ajuste_ctrl_if.sv
// ============================================================================
// relogio_ajuste_ctrl_if : buttons, current time and counter-control signals
// Revision               : 1.0
// ============================================================================
`default_nettype none

interface relogio_ajuste_ctrl_if;
   import relogio_pkg::*;

   logic               btn_mode;
   logic               btn_inc;
   logic [HORAS_W-1:0] cur_horas;
   logic [MIN_W-1:0]   cur_minutos;
   logic               tick_1hz;
   logic               load;
   logic [HORAS_W-1:0] load_horas;
   logic [MIN_W-1:0]   load_minutos;
   logic [1:0]         modo;
   logic               blink;

   modport master (
      output btn_mode, btn_inc, cur_horas, cur_minutos,
      input  tick_1hz, load, load_horas, load_minutos, modo, blink
   );

   modport slave (
      input  btn_mode, btn_inc, cur_horas, cur_minutos,
      output tick_1hz, load, load_horas, load_minutos, modo, blink
   );

endinterface

`default_nettype wire

// File: rtl/relogio_btn_repeat.sv
// ============================================================================
// relogio_btn_repeat : rising-edge pulse plus hold-to-repeat for one button
// Revision           : 1.0
// ============================================================================
`default_nettype none

module relogio_btn_repeat #(
   parameter int REP_DLY = 25_000_000,
   parameter int REP_PER = 5_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   input  logic clr,
   input  logic en,
   output logic pulse
);

   localparam int CNT_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REP_DLY - 1);
   localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REP_PER - 1);

   logic             hist;
   logic             held;
   logic             in_period;
   logic [CNT_W-1:0] cnt;
   logic             btn_rise;
   logic             rep_hit;

   assign btn_rise = btn & ~hist;
   assign rep_hit  = held & btn & (cnt == (in_period ? PER_LAST : DLY_LAST));
   assign pulse    = en & ~clr & (btn_rise | rep_hit);

   // cnt holds (cycles since last edge/repeat) - 1, so a hit lands exactly on the target cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist      <= 1'b1;
         held      <= 1'b0;
         in_period <= 1'b0;
         cnt       <= '0;
      end else begin
         hist <= btn;
         if (clr || !en || !btn) begin
            held      <= 1'b0;
            in_period <= 1'b0;
            cnt       <= '0;
         end else if (btn_rise) begin
            held      <= 1'b1;
            in_period <= 1'b0;
            cnt       <= '0;
         end else if (rep_hit) begin
            in_period <= 1'b1;
            cnt       <= '0;
         end else if (held) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/relogio_ajuste_ctrl.sv
// ============================================================================
// relogio_ajuste_ctrl : 1 Hz strobe generation and two-button hh:mm editing
// Revision            : 1.0
// ============================================================================
`default_nettype none

module relogio_ajuste_ctrl #(
   parameter int CLK_DIV = 50_000_000,
   parameter int REP_DLY = 25_000_000,
   parameter int REP_PER = 5_000_000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   relogio_ajuste_ctrl_if.slave bus
);
   import relogio_pkg::*;

   localparam int PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BLK_N   = CLK_DIV / 4;
   localparam int BLK_W   = (BLK_N > 1) ? $clog2(BLK_N) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);
   localparam logic [BLK_W-1:0]   BLK_LAST   = BLK_W'(BLK_N - 1);

   estado_t            state;
   logic               mode_hist;
   logic               mode_edge;
   logic [PRESC_W-1:0] presc;
   logic [BLK_W-1:0]   blk_cnt;
   logic [HORAS_W-1:0] edit_h;
   logic [MIN_W-1:0]   edit_m;
   logic               tick_r;
   logic               load_r;
   logic               blink_r;
   logic [HORAS_W-1:0] load_h_r;
   logic [MIN_W-1:0]   load_m_r;
   logic               inc_pulse;
   logic               inc_en;

   assign mode_edge = bus.btn_mode & ~mode_hist;
   assign inc_en    = (state != RUN);

   relogio_btn_repeat #(
      .REP_DLY (REP_DLY),
      .REP_PER (REP_PER)
   ) u_inc (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (bus.btn_inc),
      .clr   (mode_edge),
      .en    (inc_en),
      .pulse (inc_pulse)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         mode_hist <= 1'b1;
         presc     <= '0;
         blk_cnt   <= '0;
         edit_h    <= '0;
         edit_m    <= '0;
         tick_r    <= 1'b0;
         load_r    <= 1'b0;
         blink_r   <= 1'b0;
         load_h_r  <= '0;
         load_m_r  <= '0;
      end else begin
         mode_hist <= bus.btn_mode;
         tick_r    <= 1'b0;
         load_r    <= 1'b0;
         if (mode_edge) begin
            // A mode edge always wins over any increment in the same cycle.
            state   <= prox_estado(state);
            presc   <= '0;
            blk_cnt <= '0;
            blink_r <= (prox_estado(state) != RUN);
            case (state)
               RUN: begin
                  edit_h <= bus.cur_horas;
                  edit_m <= bus.cur_minutos;
               end
               SET_M: begin
                  load_r   <= 1'b1;
                  load_h_r <= edit_h;
                  load_m_r <= edit_m;
               end
               default: ;
            endcase
         end else if (state == RUN) begin
            blink_r <= 1'b0;
            blk_cnt <= '0;
            if (presc == PRESC_LAST) begin
               presc  <= '0;
               tick_r <= 1'b1;
            end else begin
               presc <= presc + 1'b1;
            end
         end else begin
            presc <= '0;
            if (blk_cnt == BLK_LAST) begin
               blk_cnt <= '0;
               blink_r <= ~blink_r;
            end else begin
               blk_cnt <= blk_cnt + 1'b1;
            end
            if (inc_pulse) begin
               if (state == SET_H)
                  edit_h <= inc_horas(edit_h);
               else if (state == SET_M)
                  edit_m <= inc_minutos(edit_m);
            end
         end
      end
   end

   assign bus.tick_1hz     = tick_r;
   assign bus.load         = load_r;
   assign bus.load_horas   = load_h_r;
   assign bus.load_minutos = load_m_r;
   assign bus.modo         = state;
   assign bus.blink        = blink_r;

endmodule

`default_nettype wire

// File: tb/tb_relogio_ajuste_ctrl.sv
// ============================================================================
// tb_relogio_ajuste_ctrl : directed + random stimulus against a cycle-count model
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_relogio_ajuste_ctrl;

   localparam int CLK_DIV = 8;
   localparam int REP_DLY = 6;
   localparam int REP_PER = 3;

   logic clk;
   logic rst_n;

   relogio_ajuste_ctrl_if bus ();

   relogio_ajuste_ctrl #(
      .CLK_DIV (CLK_DIV),
      .REP_DLY (REP_DLY),
      .REP_PER (REP_PER)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int ticks_seen = 0;

   // Reference model: mode as 0/1/2 and elapsed-cycle counts since entering each mode.
   int m_mode, m_eh, m_em, m_since_run, m_since_set, m_inc_age;
   int m_mode_prev, m_inc_prev;
   int exp_tick, exp_load, exp_lh, exp_lm, exp_blink;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset(input int bm, input int bi);
      m_mode = 0; m_eh = 0; m_em = 0;
      m_since_run = 0; m_since_set = 0; m_inc_age = -1;
      m_mode_prev = bm; m_inc_prev = bi;
      m_mode_prev = 1; m_inc_prev = 1;
      exp_tick = 0; exp_load = 0; exp_lh = 0; exp_lm = 0; exp_blink = 0;
   endtask

   task automatic model_step(input int bm, input int bi, input int ch, input int cm);
      int mode_rise, inc_rise, do_inc;
      mode_rise = bm && !m_mode_prev;
      inc_rise  = bi && !m_inc_prev;
      m_mode_prev = bm;
      m_inc_prev  = bi;
      exp_tick = 0;
      exp_load = 0;
      if (mode_rise) begin
         if (m_mode == 0) begin m_eh = ch; m_em = cm; end
         if (m_mode == 2) begin exp_load = 1; exp_lh = m_eh; exp_lm = m_em; end
         m_mode = (m_mode + 1) % 3;
         m_since_run = 0;
         m_since_set = 0;
         m_inc_age = -1;
      end else if (m_mode == 0) begin
         m_since_run++;
         exp_tick = (m_since_run % CLK_DIV == 0);
         m_inc_age = -1;
      end else begin
         m_since_set++;
         do_inc = 0;
         if (!bi) m_inc_age = -1;
         else if (inc_rise) begin m_inc_age = 0; do_inc = 1; end
         else if (m_inc_age >= 0) begin
            m_inc_age++;
            do_inc = (m_inc_age >= REP_DLY) && ((m_inc_age - REP_DLY) % REP_PER == 0);
         end
         if (do_inc) begin
            if (m_mode == 1) m_eh = (m_eh + 1) % 24;
            else             m_em = (m_em + 1) % 60;
         end
      end
      exp_blink = (m_mode != 0) && (((m_since_set / (CLK_DIV / 4)) % 2) == 0);
   endtask

   task automatic compare_all();
      check_eq("modo", bus.modo, m_mode);
      check_eq("tick_1hz", bus.tick_1hz, exp_tick);
      check_eq("load", bus.load, exp_load);
      check_eq("blink", bus.blink, exp_blink);
      if (exp_load != 0) begin
         check_eq("load_horas", bus.load_horas, exp_lh);
         check_eq("load_minutos", bus.load_minutos, exp_lm);
      end
      if (bus.tick_1hz === 1'b1) ticks_seen++;
   endtask

   task automatic cyc(input logic bm, input logic bi);
      int ch, cm;
      bus.btn_mode = bm;
      bus.btn_inc  = bi;
      ch = int'(bus.cur_horas);
      cm = int'(bus.cur_minutos);
      @(posedge clk);
      model_step(int'(bm), int'(bi), ch, cm);
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset(input logic bm, input logic bi);
      bus.btn_mode = bm;
      bus.btn_inc  = bi;
      rst_n = 1'b0;
      #1;
      check_eq("rst_modo", bus.modo, 0);
      check_eq("rst_load", bus.load, 0);
      check_eq("rst_tick", bus.tick_1hz, 0);
      check_eq("rst_blink", bus.blink, 0);
      check_eq("rst_load_horas", bus.load_horas, 0);
      model_reset(int'(bm), int'(bi));
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic press_mode();
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
   endtask

   initial begin
      logic bm_r, bi_r;
      bus.cur_horas   = '0;
      bus.cur_minutos = '0;
      do_reset(1'b0, 1'b0);

      // Idle RUN: ticks on cycles 8, 16, 24.
      ticks_seen = 0;
      repeat (24) cyc(1'b0, 1'b0);
      check_eq("tick_count_24", ticks_seen, 3);

      // 23:59 -> hours wrap to 0, load 00:59, next tick 8 cycles later.
      bus.cur_horas = 5'd23; bus.cur_minutos = 6'd59;
      cyc(1'b1, 1'b0);
      repeat (5) cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
      press_mode();
      cyc(1'b1, 1'b0);
      ticks_seen = 0;
      repeat (8) cyc(1'b0, 1'b0);
      check_eq("tick_after_load", ticks_seen, 1);

      // SET_M, minutes 58, inc held 13 cycles: 59, 0, 1, 2.
      bus.cur_horas = 5'd10; bus.cur_minutos = 6'd58;
      press_mode();
      press_mode();
      repeat (13) cyc(1'b0, 1'b1);
      repeat (6) cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      check_eq("held_load_min", bus.load_minutos, 2);
      cyc(1'b0, 1'b0);

      // Mode and inc rising together in SET_H: transition only.
      bus.cur_horas = 5'd7; bus.cur_minutos = 6'd30;
      press_mode();
      cyc(1'b1, 1'b1);
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      check_eq("simul_load_h", bus.load_horas, 7);
      cyc(1'b0, 1'b0);

      // Reset mid-SET_M with btn_mode held across release.
      press_mode();
      press_mode();
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
      do_reset(1'b1, 1'b0);
      repeat (4) cyc(1'b1, 1'b0);
      repeat (2) cyc(1'b0, 1'b0);
      press_mode();
      press_mode();
      press_mode();

      // Inc activity in RUN leaves the tick cadence alone.
      for (int i = 0; i < 24; i++) cyc(1'b0, logic'((i / 3) % 2));

      // Randomized buttons, current time and occasional resets.
      bm_r = 1'b0; bi_r = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 11) == 0) bm_r = ~bm_r;
         if ($urandom_range(0, 7) == 0)  bi_r = ~bi_r;
         bus.cur_horas   = 5'($urandom_range(0, 23));
         bus.cur_minutos = 6'($urandom_range(0, 59));
         if ($urandom_range(0, 599) == 0) do_reset(bm_r, bi_r);
         else                             cyc(bm_r, bi_r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
